// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: time-sliced round-robin owner of the shared 6-digit
// seg_led display. A granted requester keeps the display for a minimum
// dwell, then the grant rotates to the next pending requester. An idle
// display is blanked.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no owner, grant is zero, display blanked
// S_SHOW | one requester owns the display, dwell timer running
module seg_disp_arbiter #(
    parameter int N_REQ     = 3,
    parameter int DATA_W    = 20,
    parameter int DWELL_CYC = 25_000_000
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    input  logic [N_REQ*6-1:0]      i_req_point,
    input  logic [N_REQ-1:0]        i_req_sign,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_switch_pulse,
    output logic [DATA_W-1:0]       o_data,
    output logic [5:0]              o_point,
    output logic                    o_en,
    output logic                    o_sign
);

    localparam int TMR_W = $clog2(DWELL_CYC);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DWELL_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]   r_ptr;
    logic [TMR_W-1:0]   r_timer;
    logic               r_switch;
    logic [DATA_W-1:0]  r_data;
    logic [5:0]         r_point;
    logic               r_en;
    logic               r_sign;

    state_t             w_state_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;

    logic [N_REQ-1:0]   w_cand;
    logic               w_pick_valid;
    logic [PTR_W-1:0]   w_pick_idx;
    logic [PTR_W-1:0]   w_scan_idx;
    logic [N_REQ-1:0]   w_pick_onehot;
    logic [PTR_W-1:0]   w_pick_ptr;
    logic               w_owner_req;

    logic [DATA_W-1:0]  w_sel_data;
    logic [5:0]         w_sel_point;
    logic               w_sel_sign;

    // The current owner is never a candidate: on release its request is
    // already low, on expiry it must yield to anyone else pending.
    assign w_cand        = i_req & ~r_grant;
    assign w_owner_req   = |(i_req & r_grant);
    assign w_pick_onehot = ONE_HOT0 << w_pick_idx;
    assign w_pick_ptr    = PTR_W'((int'(w_pick_idx) + 1) % N_REQ);

    // Round-robin search from r_ptr upward; scanning offsets high to low
    // lets the nearest candidate overwrite the farther ones.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_scan_idx = PTR_W'((int'(r_ptr) + off) % N_REQ);
            if (w_cand[w_scan_idx]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    // Next-state logic: grant, pointer and dwell timer.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_timer_nxt = r_timer;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = S_SHOW;
                    w_grant_nxt = w_pick_onehot;
                    w_ptr_nxt   = w_pick_ptr;
                    w_timer_nxt = '0;
                end
            end
            S_SHOW: begin
                if (!w_owner_req) begin
                    // Release ignores the dwell and wins over a coincident expiry.
                    w_timer_nxt = '0;
                    if (w_pick_valid) begin
                        w_grant_nxt = w_pick_onehot;
                        w_ptr_nxt   = w_pick_ptr;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (r_timer == TMR_LAST) begin
                    // Dwell over: rotate if anyone waits, else re-arm for the owner.
                    w_timer_nxt = '0;
                    if (w_pick_valid) begin
                        w_grant_nxt = w_pick_onehot;
                        w_ptr_nxt   = w_pick_ptr;
                    end
                end else begin
                    w_timer_nxt = r_timer + TMR_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Select the live slice of the current owner; all zero when idle.
    always_comb begin
        w_sel_data  = '0;
        w_sel_point = '0;
        w_sel_sign  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_sel_data  = i_req_data[i*DATA_W +: DATA_W];
                w_sel_point = i_req_point[i*6 +: 6];
                w_sel_sign  = i_req_sign[i];
            end
        end
    end

    // Arbiter state register with synchronous active-low reset.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_ptr    <= '0;
            r_timer  <= '0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_ptr    <= w_ptr_nxt;
            r_timer  <= w_timer_nxt;
            r_switch <= (w_grant_nxt != r_grant);
        end
    end

    // Display register: one cycle behind the grant, blanked when idle.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            r_data  <= '0;
            r_point <= '0;
            r_en    <= 1'b0;
            r_sign  <= 1'b0;
        end else begin
            r_data  <= w_sel_data;
            r_point <= w_sel_point;
            r_en    <= |r_grant;
            r_sign  <= w_sel_sign;
        end
    end

    assign o_grant        = r_grant;
    assign o_switch_pulse = r_switch;
    assign o_data         = r_data;
    assign o_point        = r_point;
    assign o_en           = r_en;
    assign o_sign         = r_sign;

endmodule
